// File: rtl/data_memory_arbiter_if.sv
// ----------------------------------------------------------------------------
// data_memory_arbiter_if
//
// Purpose: groups the signals around the shared data memory. This covers the
// MEM-stage request/response, the debug/loader req/grant handshake, and the
// single-port RAM address/data.
//
// Modports:
//   slave  - the arbiter's view. Requests and RAM read data come in; stall,
//            grant, read data and the RAM controls go out.
//   master - the surrounding environment's view (pipeline, debug port, RAM).
//
// Signals:
//   pipeMemRead/pipeMemWrite/pipeAddress/pipeWriteData  MEM-stage request
//   pipeReadData/pipeStall                              MEM-stage response
//   dbgRequest/dbgWrite/dbgAddress/dbgWriteData         debug request
//   dbgGrant/dbgReadData                                debug response
//   memAddress/memWriteEnable/memWriteData              RAM inputs
//   memReadData                                         RAM output (1-cycle latency)
// ----------------------------------------------------------------------------
interface data_memory_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 8
) ();
    logic                  pipeMemRead;
    logic                  pipeMemWrite;
    logic [31:0]           pipeAddress;
    logic [31:0]           pipeWriteData;
    logic [31:0]           pipeReadData;
    logic                  pipeStall;

    logic                  dbgRequest;
    logic                  dbgWrite;
    logic [ADDR_WIDTH-1:0] dbgAddress;
    logic [31:0]           dbgWriteData;
    logic                  dbgGrant;
    logic [31:0]           dbgReadData;

    logic [ADDR_WIDTH-1:0] memAddress;
    logic                  memWriteEnable;
    logic [31:0]           memWriteData;
    logic [31:0]           memReadData;

    modport slave (
        input  pipeMemRead, pipeMemWrite, pipeAddress, pipeWriteData,
        input  dbgRequest, dbgWrite, dbgAddress, dbgWriteData,
        input  memReadData,
        output pipeReadData, pipeStall,
        output dbgGrant, dbgReadData,
        output memAddress, memWriteEnable, memWriteData
    );

    modport master (
        output pipeMemRead, pipeMemWrite, pipeAddress, pipeWriteData,
        output dbgRequest, dbgWrite, dbgAddress, dbgWriteData,
        output memReadData,
        input  pipeReadData, pipeStall,
        input  dbgGrant, dbgReadData,
        input  memAddress, memWriteEnable, memWriteData
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// ----------------------------------------------------------------------------
// data_memory_arbiter
//
// Purpose: shares the single-port synchronous data RAM between the MEM stage
// (priority requester) and a debug/loader port (req/grant). It stalls the
// pipeline for the extra cycle of a load, and while a debug access holds the
// port.
//
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous active-low reset; while low, memWriteEnable,
//            pipeStall, dbgGrant and memAddress are forced to 0
//   bus    - data_memory_arbiter_if.slave (pipeline, debug and RAM signals)
//
// Parameters:
//   ADDR_WIDTH   - RAM word-address width
//   STARVE_LIMIT - lost IDLE cycles after which a waiting debug request
//                  overrides the pipeline (guard build only)
//
// Build option:
//   DMEM_ARB_STARVE_GUARD_EN - when defined, builds the debug starvation guard
//   (waitCount plus the STARVE_LIMIT override). When undefined, the pipeline
//   has strict priority.
// ----------------------------------------------------------------------------
module data_memory_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    data_memory_arbiter_if.slave   bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_P_READ = 2'd1;
    localparam logic [1:0] S_D_WAIT = 2'd2;
    localparam logic [1:0] S_D_ACK  = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_nextState;
    logic                  r_dbgIsRead;
    logic [31:0]           r_dbgReadData;

    logic                  w_pipeReq;
    logic                  w_starve;
    logic                  w_dbgWin;
    logic [ADDR_WIDTH-1:0] w_memAddress;
    logic                  w_memWriteEnable;
    logic [31:0]           w_memWriteData;
    logic                  w_pipeStall;
    logic                  w_dbgGrant;

    // Only the word-address bits of the byte address reach the RAM.
    wire w_unused_addr = &{1'b0, bus.pipeAddress[31:ADDR_WIDTH+2], bus.pipeAddress[1:0]};

    assign w_pipeReq = bus.pipeMemRead | bus.pipeMemWrite;

    // The debug port wins an IDLE cycle when the pipeline is quiet, or when it
    // has waited long enough (guard build only).
    assign w_dbgWin = (r_state == S_IDLE) && bus.dbgRequest && (!w_pipeReq || w_starve);

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int unsigned WC_W = ($clog2(STARVE_LIMIT + 1) > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [WC_W-1:0] r_waitCount;

    assign w_starve = (32'(r_waitCount) >= 32'(STARVE_LIMIT));

    // Counts IDLE cycles that a pending debug request loses to the pipeline.
    // The count saturates at the limit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_waitCount <= '0;
        end else if (!bus.dbgRequest || w_dbgWin) begin
            r_waitCount <= '0;
        end else if ((r_state == S_IDLE) && w_pipeReq && !w_starve) begin
            r_waitCount <= r_waitCount + WC_W'(1);
        end
    end
`else
    assign w_starve = 1'b0;

    wire w_unused_limit = (STARVE_LIMIT != 0);
`endif

    always_comb begin
        w_nextState      = r_state;
        w_memAddress     = bus.pipeAddress[ADDR_WIDTH+1:2];
        w_memWriteEnable = 1'b0;
        w_memWriteData   = bus.pipeWriteData;
        w_pipeStall      = 1'b0;
        w_dbgGrant       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_dbgWin) begin
                    w_memAddress     = bus.dbgAddress;
                    w_memWriteEnable = bus.dbgWrite;
                    w_memWriteData   = bus.dbgWriteData;
                    w_pipeStall      = w_pipeReq;
                    w_nextState      = S_D_WAIT;
                end else if (bus.pipeMemWrite) begin
                    // A write takes precedence over a simultaneous read.
                    w_memWriteEnable = 1'b1;
                end else if (bus.pipeMemRead) begin
                    w_pipeStall = 1'b1;
                    w_nextState = S_P_READ;
                end
            end
            S_P_READ: begin
                w_nextState = S_IDLE;
            end
            S_D_WAIT: begin
                w_pipeStall = w_pipeReq;
                w_nextState = S_D_ACK;
            end
            S_D_ACK: begin
                w_pipeStall = w_pipeReq;
                w_dbgGrant  = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_dbgIsRead   <= 1'b0;
            r_dbgReadData <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_dbgWin) begin
                r_dbgIsRead <= !bus.dbgWrite;
            end
            // RAM data for the access issued in IDLE is on memReadData now.
            if ((r_state == S_D_WAIT) && r_dbgIsRead) begin
                r_dbgReadData <= bus.memReadData;
            end
        end
    end

    // While reset is low, the control outputs are held at zero whatever the inputs are.
    assign bus.memAddress     = reset ? w_memAddress : '0;
    assign bus.memWriteEnable = reset & w_memWriteEnable;
    assign bus.memWriteData   = w_memWriteData;
    assign bus.pipeStall      = reset & w_pipeStall;
    assign bus.dbgGrant       = reset & w_dbgGrant;
    assign bus.pipeReadData   = bus.memReadData;
    assign bus.dbgReadData    = r_dbgReadData;

endmodule
